cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Collects completed results from the execution units and broadcasts at most one per cycle on the common data bus (CDB) consumed by the ROB and reservation stations. Drives the ROB's Cdb_rd_tag / Cdb_valid / Cdb_data / Cdb_branch / Cdb_branch_taken inputs. Each requester has a one-entry holding slot with a valid/ready handshake. A round-robin arbiter picks the winner, and the winner is loaded into a registered CDB output stage.

## Interface
- NUM_REQ, 4, number of requesting execution units
- TAG_W, 5, ROB tag width
- DATA_W, 32, result data width
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- flush  in  1  synchronous; drop all pending results (branch mispredict recovery)
- req_valid  in  NUM_REQ  requester i has a result
- req_ready  out  NUM_REQ  holding slot i can accept this cycle
- req_tag  in  NUM_REQ*TAG_W  packed rd tags; slice i = [i*TAG_W +: TAG_W]
- req_data  in  NUM_REQ*DATA_W  packed result data
- req_branch  in  NUM_REQ  result is from a branch
- req_branch_taken  in  NUM_REQ  branch resolved taken
- Cdb_valid  out  1  broadcast valid
- Cdb_rd_tag  out  TAG_W  broadcast tag
- Cdb_data  out  DATA_W  broadcast data
- Cdb_branch  out  1  broadcast is a branch
- Cdb_branch_taken  out  1  branch taken
- Cdb_src  out  clog2(NUM_REQ)  index of the requester that won this broadcast

## Operation
- Holding slot i has fields: hold_valid, tag, data, branch, taken.
- Accept: when req_valid[i] && req_ready[i] at a clock edge, the slot loads and hold_valid[i]=1.
- req_ready[i] = !hold_valid[i] || grant[i]. Combinational, so a slot can be refilled at the same edge it is drained.
- Arbitration is combinational over hold_valid. Search starts at rr_ptr and wraps modulo NUM_REQ. The first valid slot wins. grant is one-hot or zero.
- On a grant to slot i at an edge:
  - the Cdb_* registers load slot i's fields;
  - Cdb_valid=1 and Cdb_src=i;
  - hold_valid[i] clears, unless the slot is refilled at the same edge;
  - rr_ptr = (i+1) mod NUM_REQ.
- No grant at an edge: Cdb_valid=0. Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken and Cdb_src hold their last values. rr_ptr is unchanged.
- flush at an edge:
  - all hold_valid clear and Cdb_valid=0;
  - rr_ptr resets to 0;
  - req_ready is forced to all-ones and any presented requests are discarded;
  - flush has priority over accept and grant.
- A slot never exceeds one entry, and there are no drops outside flush.

## Timing
- Reset values: all hold_valid=0, rr_ptr=0. Every output is 0 except req_ready, which is all-ones.
- Latency: a result accepted at edge k is broadcast at edge k+1 at the earliest (Cdb_valid high during cycle k+1..k+2). Worst case is k+NUM_REQ.
- Throughput: one broadcast per cycle. Each requester sustains one result per cycle while it is granted every cycle.
- Fairness: with all slots permanently full, grants rotate 0,1,2,3,0,…
- Asynchronous reset mid-operation clears everything immediately. No partial broadcast appears after reset deasserts.
- flush and a req_valid in the same cycle: the request is lost. The requester sees ready=1 and treats it as consumed.

## Configuration
- CDB_ARB_BRANCH_PRIO_EN is the only compile-time option.
- Defined: any held slot with branch=1 wins over non-branch slots, so mispredicts resolve early. Among several branch slots, round-robin from rr_ptr applies. rr_ptr still updates to winner+1.
- Undefined: pure round-robin, and the branch field has no effect on arbitration.

## Structure
- Package cdb_pkg holds:
  - TAG_W and DATA_W localparams;
  - typedef cdb_msg_t {tag, data, branch, taken}, used for both the holding slots and the CDB register.
- Sub-module rr_arbiter (NUM_REQ): contains the rotating-priority pick, the rr_ptr register and the optional branch-priority mask input.
- The top level holds the slot array, the handshake logic and the CDB output register.

## Test plan
- Single result: req0 tag=3, data=0x1234, asserted for one cycle after reset → Cdb_valid pulses exactly one cycle later with tag=3, data=0x1234, src=0. Cdb_valid is then 0.
- Four simultaneous results: tags 4,5,6,7 on req0–3 → broadcast order 4,5,6,7 on consecutive cycles. Each req_ready is low until its own grant.
- Saturation: all four requesters hold valid for 20 cycles → grants strictly rotate 0,1,2,3. No tag is lost or duplicated, and each requester gets 5 grants.
- Branch priority: rr_ptr=0, slots 0–2 hold non-branch results, slot 3 holds tag=10 with branch=1, taken=1 →
  - with CDB_ARB_BRANCH_PRIO_EN: tag 10 is broadcast first with Cdb_branch=1, Cdb_branch_taken=1;
  - without it: tag 10 is broadcast fourth.
- Flush: three slots full and flush asserted for one cycle → no Cdb_valid afterwards. The next request on req2 (tag=1) is broadcast with src=2 via rr_ptr=0 search.
- Reset mid-stream: assert reset while slots are full and Cdb_valid=1 → all outputs return to reset values immediately. No broadcast occurs after release until a new request arrives.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared widths and the result message carried by the holding slots
// and the CDB output register of cdb_arbiter.
package cdb_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned TAG_W       = 5;
  localparam int unsigned DATA_W      = 32;

  // One completed result: destination ROB tag, value and branch outcome.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
    logic              branch;
    logic              taken;
  } cdb_msg_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester-side valid/ready results plus the broadcast CDB.
//   master : execution units / ROB side (drives req_*, observes ready and Cdb_*)
//   slave  : cdb_arbiter side (observes req_*, drives req_ready and Cdb_*)
//   req_tag / req_data are packed per requester: slice i = [i*W +: W].
interface cdb_arbiter_if #(
  parameter int unsigned NUM_REQ = cdb_pkg::NUM_REQ_DEF
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                req_valid;
  logic [NUM_REQ-1:0]                req_ready;
  logic [NUM_REQ*cdb_pkg::TAG_W-1:0]  req_tag;
  logic [NUM_REQ*cdb_pkg::DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]                req_branch;
  logic [NUM_REQ-1:0]                req_branch_taken;

  logic                        Cdb_valid;
  logic [cdb_pkg::TAG_W-1:0]   Cdb_rd_tag;
  logic [cdb_pkg::DATA_W-1:0]  Cdb_data;
  logic                        Cdb_branch;
  logic                        Cdb_branch_taken;
  logic [IDX_W-1:0]            Cdb_src;

  modport master (
    output req_valid, req_tag, req_data, req_branch, req_branch_taken,
    input  req_ready,
    input  Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken, Cdb_src
  );

  modport slave (
    input  req_valid, req_tag, req_data, req_branch, req_branch_taken,
    output req_ready,
    output Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken, Cdb_src
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// rr_arbiter: rotating-priority single-winner pick with its own pointer.
//   clock, reset (async, active-high), flush (sync pointer clear)
//   req         : candidates (held slots)
//   prio        : preferred candidates; if any preferred candidate is
//                 requesting, only those compete (round-robin among them)
//   grant_c     : one-hot or zero winner (combinational)
//   grant_idx_c : winner index, grant_valid_c : a winner exists
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         prio,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_c,
  output logic                       grant_valid_c
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0]   rr_ptr;
  logic [NUM_REQ-1:0] eff_req;
  logic [IDX_W-1:0]   cand_idx;
  logic               found;

  // Narrow the field to preferred candidates only when one is present.
  always_comb begin
    eff_req = req;
    if ((req & prio) != '0) eff_req = req & prio;
  end

  // First requesting slot at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    grant_c       = '0;
    grant_idx_c   = '0;
    grant_valid_c = 1'b0;
    found         = 1'b0;
    cand_idx      = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand_idx = IDX_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!found && eff_req[cand_idx]) begin
        found       = 1'b1;
        grant_idx_c = cand_idx;
      end
    end
    grant_valid_c = found;
    if (found) grant_c[grant_idx_c] = 1'b1;
  end

  // Pointer moves one past the winner; flush restarts the search at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (flush) begin
      rr_ptr <= '0;
    end else if (grant_valid_c) begin
      if (grant_idx_c == IDX_W'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                   rr_ptr <= IDX_W'(grant_idx_c + IDX_W'(1));
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: collects execution-unit results into one-entry holding slots
// and broadcasts at most one per cycle on the registered common data bus.
//   clock, reset (async, active-high)
//   flush : synchronous drop of all held results, forces req_ready high
//   bus   : cdb_arbiter_if.slave (req_* handshake in, Cdb_* broadcast out)
// Compile option CDB_ARB_BRANCH_PRIO_EN: held branch results win over
// non-branch results; undefined gives pure round-robin.
module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  cdb_arbiter_if.slave        bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  cdb_msg_t           slot_q [NUM_REQ];
  cdb_msg_t           req_msg [NUM_REQ];
  logic [NUM_REQ-1:0] hold_valid;
  logic [NUM_REQ-1:0] prio;
  logic [NUM_REQ-1:0] accept;
  logic [NUM_REQ-1:0] grant_c;
  logic [IDX_W-1:0]   grant_idx_c;
  logic               grant_valid_c;

  cdb_msg_t           cdb_q;
  logic               cdb_valid_q;
  logic [IDX_W-1:0]   cdb_src_q;

  // Unpack the per-requester slices into messages.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      req_msg[i].tag    = bus.req_tag[i*TAG_W +: TAG_W];
      req_msg[i].data   = bus.req_data[i*DATA_W +: DATA_W];
      req_msg[i].branch = bus.req_branch[i];
      req_msg[i].taken  = bus.req_branch_taken[i];
    end
  end

`ifdef CDB_ARB_BRANCH_PRIO_EN
  // Held branches are preferred so mispredicts reach the ROB early.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) prio[i] = slot_q[i].branch;
  end
`else
  assign prio = '0;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .req           (hold_valid),
    .prio          (prio),
    .grant_c       (grant_c),
    .grant_idx_c   (grant_idx_c),
    .grant_valid_c (grant_valid_c)
  );

  // A slot being drained this edge may be refilled at the same edge.
  always_comb begin
    bus.req_ready = ~hold_valid | grant_c;
    if (flush) bus.req_ready = '1;
    accept = bus.req_valid & bus.req_ready & ~{NUM_REQ{flush}};
  end

  // Holding slots: load on accept, clear on grant, flush drops everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_valid <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) slot_q[i] <= '0;
    end else if (flush) begin
      hold_valid <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (accept[i]) begin
          hold_valid[i] <= 1'b1;
          slot_q[i]     <= req_msg[i];
        end else if (grant_c[i]) begin
          hold_valid[i] <= 1'b0;
        end
      end
    end
  end

  // CDB stage: payload holds its last value when nothing is granted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cdb_q       <= '0;
      cdb_valid_q <= 1'b0;
      cdb_src_q   <= '0;
    end else if (flush) begin
      cdb_valid_q <= 1'b0;
    end else if (grant_valid_c) begin
      cdb_q       <= slot_q[grant_idx_c];
      cdb_valid_q <= 1'b1;
      cdb_src_q   <= grant_idx_c;
    end else begin
      cdb_valid_q <= 1'b0;
    end
  end

  assign bus.Cdb_valid        = cdb_valid_q;
  assign bus.Cdb_rd_tag       = cdb_q.tag;
  assign bus.Cdb_data         = cdb_q.data;
  assign bus.Cdb_branch       = cdb_q.branch;
  assign bus.Cdb_branch_taken = cdb_q.taken;
  assign bus.Cdb_src          = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed self-checking bench for cdb_arbiter (NUM_REQ=4).
module tb_cdb_arbiter;
  import cdb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  logic flush;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  cdb_arbiter_if #(.NUM_REQ(4)) bus ();

  cdb_arbiter #(.NUM_REQ(4)) dut (
    .clock (clock),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  task automatic set_req(input int i, input logic [4:0] tag, input logic [31:0] data,
                         input logic br, input logic tk);
    bus.req_valid[i]         = 1'b1;
    bus.req_tag[i*5 +: 5]    = tag;
    bus.req_data[i*32 +: 32] = data;
    bus.req_branch[i]        = br;
    bus.req_branch_taken[i]  = tk;
  endtask

  task automatic clear_reqs();
    bus.req_valid        = '0;
    bus.req_tag          = '0;
    bus.req_data         = '0;
    bus.req_branch       = '0;
    bus.req_branch_taken = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    flush = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.Cdb_valid, bus.Cdb_branch, bus.Cdb_branch_taken} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000",
               {bus.Cdb_valid, bus.Cdb_branch, bus.Cdb_branch_taken});
    end
    checks++;
    if ({bus.Cdb_rd_tag, bus.Cdb_data, bus.Cdb_src} !== 39'd0) begin
      errors++;
      $display("FAIL reset_payload: got tag=%0d data=%h src=%0d expected all 0",
               bus.Cdb_rd_tag, bus.Cdb_data, bus.Cdb_src);
    end
    checks++;
    if (bus.req_ready !== 4'hf) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1111", bus.req_ready);
    end
  endtask

  task automatic test_single();
    apply_reset();
    set_req(0, 5'd3, 32'h1234, 1'b0, 1'b0);
    step();
    clear_reqs();
    checks++;
    if (bus.Cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: Cdb_valid got %b expected 0", bus.Cdb_valid);
    end
    step();
    checks++;
    if ({bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_data, bus.Cdb_src} !== {1'b1, 5'd3, 32'h1234, 2'd0}) begin
      errors++;
      $display("FAIL single_bcast: got v=%b tag=%0d data=%h src=%0d expected v=1 tag=3 data=1234 src=0",
               bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_data, bus.Cdb_src);
    end
    step();
    checks++;
    if ({bus.Cdb_valid, bus.Cdb_rd_tag} !== {1'b0, 5'd3}) begin
      errors++;
      $display("FAIL single_after: got v=%b tag=%0d expected v=0 tag=3 (held)",
               bus.Cdb_valid, bus.Cdb_rd_tag);
    end
  endtask

  task automatic test_four();
    logic [3:0] exp_ready;
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 5'(4 + i), 32'(32'h100 + i), 1'b0, 1'b0);
    step();
    clear_reqs();
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL four_ready_full: got %b expected 0001", bus.req_ready);
    end
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if ({bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_src} !== {1'b1, 5'(4 + n), 2'(n)}) begin
        errors++;
        $display("FAIL four_bcast%0d: got v=%b tag=%0d src=%0d expected v=1 tag=%0d src=%0d",
                 n, bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_src, 4 + n, n);
      end
      exp_ready = (n < 3) ? 4'((1 << (n + 2)) - 1) : 4'hf;
      checks++;
      if (bus.req_ready !== exp_ready) begin
        errors++;
        $display("FAIL four_ready%0d: got %b expected %b", n, bus.req_ready, exp_ready);
      end
    end
    step();
    checks++;
    if (bus.Cdb_valid !== 1'b0) begin
      errors++;
      $display("FAIL four_idle: Cdb_valid got %b expected 0", bus.Cdb_valid);
    end
  endtask

  task automatic test_saturation();
    logic [3:0] rdy;
    int         cnt [4];
    int         grants [4];
    int         e;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      cnt[i]    = 0;
      grants[i] = 0;
      set_req(i, {2'(i), 3'd0}, 32'(i), 1'b0, 1'b0);
    end
    for (int c = 0; c <= 20; c++) begin
      rdy = bus.req_ready;
      step();
      for (int i = 0; i < 4; i++) begin
        if (rdy[i]) begin
          cnt[i]++;
          set_req(i, {2'(i), 3'(cnt[i])}, 32'(i), 1'b0, 1'b0);
        end
      end
      if (c >= 1) begin
        e = c - 1;
        if (bus.Cdb_valid === 1'b1) grants[bus.Cdb_src]++;
        checks++;
        if ({bus.Cdb_valid, bus.Cdb_src, bus.Cdb_rd_tag} !== {1'b1, 2'(e % 4), 2'(e % 4), 3'(e / 4)}) begin
          errors++;
          $display("FAIL sat_bcast%0d: got v=%b src=%0d tag=%h expected v=1 src=%0d tag=%h",
                   e, bus.Cdb_valid, bus.Cdb_src, bus.Cdb_rd_tag, e % 4, {2'(e % 4), 3'(e / 4)});
        end
      end
    end
    clear_reqs();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (grants[i] !== 5) begin
        errors++;
        $display("FAIL sat_grants%0d: got %0d expected 5", i, grants[i]);
      end
    end
  endtask

  task automatic test_branch_prio();
    int exp_tag [4];
    int exp_src [4];
`ifdef CDB_ARB_BRANCH_PRIO_EN
    exp_tag = '{10, 1, 2, 3};
    exp_src = '{3, 0, 1, 2};
`else
    exp_tag = '{1, 2, 3, 10};
    exp_src = '{0, 1, 2, 3};
`endif
    apply_reset();
    set_req(0, 5'd1, 32'h11, 1'b0, 1'b0);
    set_req(1, 5'd2, 32'h22, 1'b0, 1'b0);
    set_req(2, 5'd3, 32'h33, 1'b0, 1'b0);
    set_req(3, 5'd10, 32'haa, 1'b1, 1'b1);
    step();
    clear_reqs();
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if ({bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_src, bus.Cdb_branch, bus.Cdb_branch_taken} !==
          {1'b1, 5'(exp_tag[n]), 2'(exp_src[n]), exp_tag[n] == 10, exp_tag[n] == 10}) begin
        errors++;
        $display("FAIL branch_order%0d: got v=%b tag=%0d src=%0d br=%b tk=%b expected tag=%0d src=%0d",
                 n, bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_src, bus.Cdb_branch,
                 bus.Cdb_branch_taken, exp_tag[n], exp_src[n]);
      end
    end
  endtask

  task automatic test_flush();
    apply_reset();
    set_req(0, 5'd11, 32'h0, 1'b0, 1'b0);
    set_req(1, 5'd12, 32'h0, 1'b0, 1'b0);
    set_req(2, 5'd13, 32'h0, 1'b0, 1'b0);
    step();
    clear_reqs();
    flush = 1'b1;
    set_req(1, 5'd20, 32'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if (bus.req_ready !== 4'hf) begin
      errors++;
      $display("FAIL flush_ready: got %b expected 1111", bus.req_ready);
    end
    step();
    flush = 1'b0;
    clear_reqs();
    checks++;
    if ({bus.Cdb_valid, bus.req_ready} !== 5'b0_1111) begin
      errors++;
      $display("FAIL flush_after: got v=%b ready=%b expected v=0 ready=1111",
               bus.Cdb_valid, bus.req_ready);
    end
    for (int n = 0; n < 3; n++) begin
      step();
      checks++;
      if (bus.Cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL flush_quiet%0d: Cdb_valid got %b expected 0", n, bus.Cdb_valid);
      end
    end
    set_req(2, 5'd1, 32'h55, 1'b0, 1'b0);
    step();
    clear_reqs();
    step();
    checks++;
    if ({bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_src, bus.Cdb_data} !== {1'b1, 5'd1, 2'd2, 32'h55}) begin
      errors++;
      $display("FAIL flush_next: got v=%b tag=%0d src=%0d data=%h expected v=1 tag=1 src=2 data=55",
               bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_src, bus.Cdb_data);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) set_req(i, 5'(20 + i), 32'(32'hbeef0 + i), 1'b1, 1'b1);
    step();
    clear_reqs();
    step();
    checks++;
    if ({bus.Cdb_valid, bus.Cdb_rd_tag} !== {1'b1, 5'd20}) begin
      errors++;
      $display("FAIL midrst_pre: got v=%b tag=%0d expected v=1 tag=20", bus.Cdb_valid, bus.Cdb_rd_tag);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_data, bus.Cdb_branch, bus.Cdb_branch_taken,
         bus.Cdb_src, bus.req_ready} !== {1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 2'd0, 4'hf}) begin
      errors++;
      $display("FAIL midrst_async: got v=%b tag=%0d data=%h br=%b tk=%b src=%0d ready=%b expected all 0, ready=1111",
               bus.Cdb_valid, bus.Cdb_rd_tag, bus.Cdb_data, bus.Cdb_branch,
               bus.Cdb_branch_taken, bus.Cdb_src, bus.req_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      step();
      checks++;
      if (bus.Cdb_valid !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet%0d: Cdb_valid got %b expected 0", n, bus.Cdb_valid);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    clear_reqs();
    test_reset();
    test_single();
    test_four();
    test_saturation();
    test_branch_prio();
    test_flush();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
